// File: rtl/pipe_ctrl.sv
// Pipeline controller: prefix stall bus, flush/redirect sequencing,
// saturating performance counters and a stall watchdog.
module pipe_ctrl #(
  parameter int NSTAGE   = 6,
  parameter int CNT_W    = 32,
  parameter int WDOG_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              hang
);

  localparam int WD_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WDOG_LIM = WD_W'(WDOG_MAX);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [NSTAGE-1:0] stall_pre;
  logic [WD_W-1:0] wdog, wdog_nxt;
  logic            stall_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (flush_req) state_nxt = FLUSH;
               else if (stallreq != '0) state_nxt = STALL;
      STALL:   if (flush_req) state_nxt = FLUSH;
               else if (stallreq == '0) state_nxt = RUN;
      FLUSH:   if (flush_req) state_nxt = FLUSH;
               else if (stallreq != '0) state_nxt = STALL;
               else state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Stage j holds whenever any stage at or beyond j requests a hold.
  always_comb begin
    stall_pre = '0;
    for (int unsigned j = 0; j < NSTAGE; j++)
      stall_pre[j] = |(stallreq >> j);
  end

  // Reset forces the combinational bus low so outputs drop immediately.
  always_comb begin
    stall = stall_pre;
    flush = 1'b0;
    if (rst) begin
      stall = '0;
    end else if (state == FLUSH) begin
      stall = '0;
      flush = 1'b1;
    end
  end

  assign stall_any = (stall != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            new_pc <= '0;
    else if (flush_req) new_pc <= flush_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_any && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    if (!stall_any)           wdog_nxt = '0;
    else if (wdog == WDOG_LIM) wdog_nxt = wdog;
    else                      wdog_nxt = wdog + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
      hang <= 1'b0;
    end else begin
      wdog <= wdog_nxt;
      if (WDOG_MAX != 0 && wdog_nxt == WDOG_LIM) hang <= 1'b1;
    end
  end

endmodule
